// File: rtl/ip_sequencer_stack.sv
// ip_sequencer_stack: instruction-pointer sequencer with a nested CALL/RET
// hardware return stack, stall input and sticky overflow/underflow flags.
// Optional build macro IPSEQ_TRAP_EN: when defined, stack errors redirect
// the IP to TRAP_VECTOR and pulse oTrap for one cycle.
module ip_sequencer_stack #(
  parameter int unsigned       ADDR_W       = 16,
  parameter int unsigned       STACK_DEPTH  = 8,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_W-1:0] TRAP_VECTOR  = 16'hFFF0
) (
  input  logic                                 Clock,
  input  logic                                 Reset,
  input  logic                                 iEnable,
  input  logic                                 iBranch,
  input  logic                                 iCall,
  input  logic                                 iRet,
  input  logic [ADDR_W-1:0]                    iTarget,
  input  logic                                 iClearErr,
  output logic [ADDR_W-1:0]                    oIP,
  output logic [$clog2(STACK_DEPTH+1)-1:0]     oDepth,
  output logic                                 oFull,
  output logic                                 oEmpty,
  output logic                                 oOverflow,
  output logic                                 oUnderflow,
  output logic                                 oTrap
);

  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int unsigned PTR_W   = $clog2(STACK_DEPTH);

  logic [ADDR_W-1:0]  ip_q, ip_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];

  logic               full, empty;
  logic [ADDR_W-1:0]  ip_inc;
  logic [ADDR_W-1:0]  top;
  logic [PTR_W-1:0]   wr_ptr, top_ptr;
  logic               push, ovf_evt, unf_evt;

  assign full    = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign empty   = (depth_q == '0);
  assign ip_inc  = ip_q + ADDR_W'(1);
  assign wr_ptr  = PTR_W'(depth_q);
  assign top_ptr = PTR_W'(depth_q - DEPTH_W'(1));
  assign top     = stack_q[top_ptr];

  // Return outranks call, so a call only acts when no return is present.
  assign push    = iEnable & ~iRet & iCall & ~full;
  assign ovf_evt = iEnable & ~iRet & iCall & full;
  assign unf_evt = iEnable & iRet & empty;

`ifdef IPSEQ_TRAP_EN
  logic trap_q, trap_d;
  logic err_redirect;
  assign err_redirect = 1'b1;
`else
  logic err_redirect;
  logic unused_trap_vector;
  assign err_redirect       = 1'b0;
  assign unused_trap_vector = ^TRAP_VECTOR;
`endif

  // Next-state for IP, depth and sticky flags; priority ret > call > branch > seq.
  always_comb begin
    ip_d    = ip_q;
    depth_d = depth_q;
    ovf_d   = iClearErr ? 1'b0 : ovf_q;
    unf_d   = iClearErr ? 1'b0 : unf_q;
    if (ovf_evt) ovf_d = 1'b1;
    if (unf_evt) unf_d = 1'b1;
    if (iEnable) begin
      if (iRet) begin
        if (!empty) begin
          ip_d    = top;
          depth_d = depth_q - DEPTH_W'(1);
        end else if (err_redirect) begin
          ip_d = TRAP_VECTOR;
        end else begin
          ip_d = ip_inc;
        end
      end else if (iCall) begin
        if (!full) begin
          ip_d    = iTarget;
          depth_d = depth_q + DEPTH_W'(1);
        end else if (err_redirect) begin
          ip_d = TRAP_VECTOR;
        end else begin
          ip_d = iTarget;
        end
      end else if (iBranch) begin
        ip_d = iTarget;
      end else begin
        ip_d = ip_inc;
      end
    end
  end

  // Control state register; async reset empties the stack and restarts the IP.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ip_q    <= RESET_VECTOR;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      ip_q    <= ip_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Return-stack storage: plain registers, written only on a successful push.
  always_ff @(posedge Clock) begin
    if (push) stack_q[wr_ptr] <= ip_inc;
  end

`ifdef IPSEQ_TRAP_EN
  assign trap_d = ovf_evt | unf_evt;

  // Trap pulse: high for the single cycle following an error edge.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) trap_q <= 1'b0;
    else        trap_q <= trap_d;
  end

  assign oTrap = trap_q;
`else
  assign oTrap = 1'b0;
`endif

  assign oIP        = ip_q;
  assign oDepth     = depth_q;
  assign oFull      = full;
  assign oEmpty     = empty;
  assign oOverflow  = ovf_q;
  assign oUnderflow = unf_q;

endmodule

// File: tb/tb_ip_sequencer_stack.sv
// Self-checking bench for ip_sequencer_stack (default parameters).
// Expected states are queued when each cycle's stimulus is driven and
// popped after the following rising edge. Honours IPSEQ_TRAP_EN.
module tb_ip_sequencer_stack;

`ifdef IPSEQ_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        Clock     = 1'b0;
  logic        Reset     = 1'b1;
  logic        iEnable   = 1'b0;
  logic        iBranch   = 1'b0;
  logic        iCall     = 1'b0;
  logic        iRet      = 1'b0;
  logic        iClearErr = 1'b0;
  logic [15:0] iTarget   = '0;
  logic [15:0] oIP;
  logic [3:0]  oDepth;
  logic        oFull, oEmpty, oOverflow, oUnderflow, oTrap;

  ip_sequencer_stack dut (
    .Clock(Clock), .Reset(Reset), .iEnable(iEnable), .iBranch(iBranch),
    .iCall(iCall), .iRet(iRet), .iTarget(iTarget), .iClearErr(iClearErr),
    .oIP(oIP), .oDepth(oDepth), .oFull(oFull), .oEmpty(oEmpty),
    .oOverflow(oOverflow), .oUnderflow(oUnderflow), .oTrap(oTrap)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [15:0] ip;
    logic [3:0]  depth;
    logic        full, empty, ovf, unf, trap;
  } exp_t;

  typedef struct packed {
    logic        en, ret, call, br, clr;
    logic [15:0] tgt;
    exp_t        exp;
  } step_t;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;

  function automatic exp_t mk(input logic [15:0] ip, input int d,
                              input logic ovf, input logic unf, input logic trap);
    exp_t e;
    e.ip    = ip;
    e.depth = 4'(d);
    e.full  = (d == 8);
    e.empty = (d == 0);
    e.ovf   = ovf;
    e.unf   = unf;
    e.trap  = trap;
    return e;
  endfunction

  function automatic step_t st(input logic en, input logic ret, input logic call,
                               input logic br, input logic clr,
                               input logic [15:0] tgt, input exp_t e);
    step_t s;
    s.en = en; s.ret = ret; s.call = call; s.br = br; s.clr = clr;
    s.tgt = tgt; s.exp = e;
    return s;
  endfunction

  // IP right after an error edge, and one sequential step after it.
  function automatic logic [15:0] err_ip(input logic [15:0] plain);
    return TRAP ? 16'hFFF0 : plain;
  endfunction
  function automatic logic [15:0] after_err_ip(input logic [15:0] plain);
    return TRAP ? 16'hFFF1 : plain;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.ip = oIP; o.depth = oDepth; o.full = oFull; o.empty = oEmpty;
    o.ovf = oOverflow; o.unf = oUnderflow; o.trap = oTrap;
    return o;
  endfunction

  function automatic string fmt(input exp_t e);
    return $sformatf("ip=%h depth=%0d full=%b empty=%b ovf=%b unf=%b trap=%b",
                     e.ip, e.depth, e.full, e.empty, e.ovf, e.unf, e.trap);
  endfunction

  task automatic drive(input step_t s);
    @(negedge Clock);
    iEnable = s.en; iRet = s.ret; iCall = s.call; iBranch = s.br;
    iClearErr = s.clr; iTarget = s.tgt;
    sb.push_back(s.exp);
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    step_t s[$];
    exp_t  got, e;
    #2 Reset = 1'b0;
    #1 got = observe();
    e = mk(16'h0000, 0, 0, 0, 0);
    tests++;
    if (got !== e) begin
      failed++;
      $display("FAIL reset_initial: got %s, required %s", fmt(got), fmt(e));
    end
    @(negedge Clock);
    Reset = 1'b1;
    s.push_back(st(1, 0, 0, 1, 0, 16'h0010, mk(16'h0010, 0, 0, 0, 0)));
    s.push_back(st(1, 0, 1, 0, 0, 16'h0020, mk(16'h0020, 1, 0, 0, 0)));
    s.push_back(st(1, 0, 1, 0, 0, 16'h0020, mk(16'h0020, 2, 0, 0, 0)));
    s.push_back(st(1, 0, 1, 0, 0, 16'h0021, mk(16'h0021, 3, 0, 0, 0)));
    s.push_back(st(1, 0, 0, 0, 0, 16'h0000, mk(16'h0022, 3, 0, 0, 0)));
    s.push_back(st(1, 0, 0, 0, 0, 16'h0000, mk(16'h0023, 3, 0, 0, 0)));
    foreach (s[i]) begin
      drive(s[i]);
      got = observe();
      tests++;
      if (sb.size() == 0) begin
        failed++;
        $display("FAIL reset_setup[%0d]: scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          failed++;
          $display("FAIL reset_setup[%0d]: got %s, required %s", i, fmt(got), fmt(e));
        end
      end
    end
    // Mid-cycle asynchronous assertion must take effect without a clock edge.
    @(negedge Clock);
    #1 Reset = 1'b0;
    #1 got = observe();
    e = mk(16'h0000, 0, 0, 0, 0);
    tests++;
    if (got !== e) begin
      failed++;
      $display("FAIL reset_async: got %s, required %s", fmt(got), fmt(e));
    end
    iEnable = 1'b0; iCall = 1'b1; iRet = 1'b1; iBranch = 1'b1; iTarget = 16'h0055;
    @(posedge Clock);
    #1 Reset = 1'b1;
    s.delete();
    for (int k = 0; k < 4; k++)
      s.push_back(st(0, 1, 1, 1, 0, 16'h0055, mk(16'h0000, 0, 0, 0, 0)));
    s.push_back(st(1, 0, 0, 0, 0, 16'h0000, mk(16'h0001, 0, 0, 0, 0)));
    s.push_back(st(1, 0, 0, 0, 0, 16'h0000, mk(16'h0002, 0, 0, 0, 0)));
    foreach (s[i]) begin
      drive(s[i]);
      got = observe();
      tests++;
      if (sb.size() == 0) begin
        failed++;
        $display("FAIL reset_stall[%0d]: scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          failed++;
          $display("FAIL reset_stall[%0d]: got %s, required %s", i, fmt(got), fmt(e));
        end
      end
    end
  endtask

  task automatic test_nested();
    step_t s[$];
    exp_t  got, e;
    s.push_back(st(1, 0, 0, 1, 0, 16'h0005, mk(16'h0005, 0, 0, 0, 0)));
    s.push_back(st(1, 0, 1, 0, 0, 16'h0040, mk(16'h0040, 1, 0, 0, 0)));
    s.push_back(st(1, 0, 0, 0, 0, 16'h0000, mk(16'h0041, 1, 0, 0, 0)));
    s.push_back(st(1, 0, 0, 0, 0, 16'h0000, mk(16'h0042, 1, 0, 0, 0)));
    s.push_back(st(1, 0, 1, 0, 0, 16'h0080, mk(16'h0080, 2, 0, 0, 0)));
    s.push_back(st(1, 1, 0, 0, 0, 16'h0000, mk(16'h0043, 1, 0, 0, 0)));
    s.push_back(st(1, 1, 0, 0, 0, 16'h0000, mk(16'h0006, 0, 0, 0, 0)));
    foreach (s[i]) begin
      drive(s[i]);
      got = observe();
      tests++;
      if (sb.size() == 0) begin
        failed++;
        $display("FAIL nested[%0d]: scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          failed++;
          $display("FAIL nested[%0d]: got %s, required %s", i, fmt(got), fmt(e));
        end
      end
    end
  endtask

  task automatic test_overflow();
    step_t s[$];
    exp_t  got, e;
    for (int k = 1; k <= 8; k++)
      s.push_back(st(1, 0, 1, 0, 0, 16'h0100, mk(16'h0100, k, 0, 0, 0)));
    s.push_back(st(1, 0, 1, 0, 0, 16'h0100, mk(err_ip(16'h0100), 8, 1, 0, TRAP)));
    s.push_back(st(1, 0, 0, 0, 0, 16'h0000, mk(after_err_ip(16'h0101), 8, 1, 0, 0)));
    for (int k = 7; k >= 1; k--)
      s.push_back(st(1, 1, 0, 0, 0, 16'h0000, mk(16'h0101, k, 1, 0, 0)));
    s.push_back(st(1, 1, 0, 0, 0, 16'h0000, mk(16'h0007, 0, 1, 0, 0)));
    s.push_back(st(0, 0, 0, 0, 1, 16'h0000, mk(16'h0007, 0, 0, 0, 0)));
    foreach (s[i]) begin
      drive(s[i]);
      got = observe();
      tests++;
      if (sb.size() == 0) begin
        failed++;
        $display("FAIL overflow[%0d]: scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          failed++;
          $display("FAIL overflow[%0d]: got %s, required %s", i, fmt(got), fmt(e));
        end
      end
    end
  endtask

  task automatic test_underflow();
    step_t s[$];
    exp_t  got, e;
    s.push_back(st(1, 0, 0, 1, 0, 16'h0010, mk(16'h0010, 0, 0, 0, 0)));
    s.push_back(st(1, 1, 0, 0, 0, 16'h0000, mk(err_ip(16'h0011), 0, 0, 1, TRAP)));
    s.push_back(st(1, 0, 0, 0, 1, 16'h0000, mk(after_err_ip(16'h0012), 0, 0, 0, 0)));
    s.push_back(st(1, 1, 0, 0, 1, 16'h0000, mk(err_ip(16'h0013), 0, 0, 1, TRAP)));
    s.push_back(st(1, 1, 1, 0, 0, 16'h0050, mk(err_ip(16'h0014), 0, 0, 1, TRAP)));
    s.push_back(st(1, 0, 0, 0, 1, 16'h0000, mk(after_err_ip(16'h0015), 0, 0, 0, 0)));
    foreach (s[i]) begin
      drive(s[i]);
      got = observe();
      tests++;
      if (sb.size() == 0) begin
        failed++;
        $display("FAIL underflow[%0d]: scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          failed++;
          $display("FAIL underflow[%0d]: got %s, required %s", i, fmt(got), fmt(e));
        end
      end
    end
  endtask

  task automatic test_priority_wrap();
    step_t s[$];
    exp_t  got, e;
    s.push_back(st(1, 0, 0, 1, 0, 16'h0032, mk(16'h0032, 0, 0, 0, 0)));
    s.push_back(st(1, 0, 1, 0, 0, 16'h0070, mk(16'h0070, 1, 0, 0, 0)));
    s.push_back(st(1, 1, 1, 1, 0, 16'h0099, mk(16'h0033, 0, 0, 0, 0)));
    s.push_back(st(1, 0, 0, 0, 0, 16'h0000, mk(16'h0034, 0, 0, 0, 0)));
    s.push_back(st(1, 0, 0, 1, 0, 16'hFFFF, mk(16'hFFFF, 0, 0, 0, 0)));
    s.push_back(st(1, 0, 0, 0, 0, 16'h0000, mk(16'h0000, 0, 0, 0, 0)));
    s.push_back(st(1, 0, 0, 1, 0, 16'hFFFF, mk(16'hFFFF, 0, 0, 0, 0)));
    s.push_back(st(1, 0, 1, 0, 0, 16'h0200, mk(16'h0200, 1, 0, 0, 0)));
    s.push_back(st(1, 1, 0, 0, 0, 16'h0000, mk(16'h0000, 0, 0, 0, 0)));
    s.push_back(st(1, 0, 1, 1, 0, 16'h0300, mk(16'h0300, 1, 0, 0, 0)));
    s.push_back(st(1, 1, 0, 0, 0, 16'h0000, mk(16'h0001, 0, 0, 0, 0)));
    foreach (s[i]) begin
      drive(s[i]);
      got = observe();
      tests++;
      if (sb.size() == 0) begin
        failed++;
        $display("FAIL priority_wrap[%0d]: scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          failed++;
          $display("FAIL priority_wrap[%0d]: got %s, required %s", i, fmt(got), fmt(e));
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nested();
    test_overflow();
    test_underflow();
    test_priority_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ip_sequencer_stack.md
# ip_sequencer_stack

Parametrised instruction-pointer sequencer for the MiniAlu-class cores. It replaces the fixed upcounter-plus-single-return-register scheme with a configurable-depth hardware return stack that supports nested CALL/RET. It adds a stall input, sticky stack error flags and an optional trap redirect. The block drives the instruction ROM address directly and receives decoded branch, call and return strobes from the execute stage.

## Interface

**Parameters**
- `ADDR_W`, 16: instruction address width.
- `STACK_DEPTH`, 8: number of return-stack entries; must be ≥ 2.
- `RESET_VECTOR`, 0: value loaded into `oIP` on reset.
- `TRAP_VECTOR`, 16'hFFF0: redirect address on a stack error. Used only when `IPSEQ_TRAP_EN` is defined.

**Ports**
- `Clock` in 1: the single clock; all state changes on its rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `iEnable` in 1: advance enable. When 0, the block stalls.
- `iBranch` in 1: taken branch or jump; load `iTarget`.
- `iCall` in 1: call; push the return address, then load `iTarget`.
- `iRet` in 1: return; pop the top entry into `oIP`.
- `iTarget` in `ADDR_W`: branch or call destination.
- `iClearErr` in 1: clears the sticky error flags.
- `oIP` out `ADDR_W`: current instruction address, registered.
- `oDepth` out `$clog2(STACK_DEPTH+1)`: number of valid stack entries.
- `oFull` out 1: `oDepth == STACK_DEPTH`.
- `oEmpty` out 1: `oDepth == 0`.
- `oOverflow` out 1: sticky; a call was issued while the stack was full.
- `oUnderflow` out 1: sticky; a return was issued while the stack was empty.
- `oTrap` out 1: one-cycle pulse on a trap redirect. Constant 0 when `IPSEQ_TRAP_EN` is undefined.

## Operation

**Command priority per enabled edge:** `iRet` > `iCall` > `iBranch` > sequential. Lower-priority strobes asserted in the same cycle are ignored. A simultaneous call and return performs only the return, with no push.

**Sequential:** `oIP <= oIP + 1`, modulo 2^`ADDR_W`. `{ADDR_W{1'b1}}` wraps to 0.

**Branch:** `oIP <= iTarget`. The stack is unchanged.

**Call, stack not full:**
- `stack[oDepth] <= oIP + 1`, modulo 2^`ADDR_W`.
- `oDepth` increments.
- `oIP <= iTarget`.

**Call, stack full:**
- `oOverflow <= 1`.
- The push is dropped; stack contents and `oDepth` are unchanged.
- `oIP` follows the Configuration section.

**Return, stack not empty:**
- `oIP <= stack[oDepth-1]`.
- `oDepth` decrements.

**Return, stack empty:**
- `oUnderflow <= 1`.
- `oIP` follows the Configuration section.

**Stall:** when `iEnable = 0`, all state holds, including `oIP`, the stack and `oDepth`. Command strobes are ignored, not queued.

**Error flags:**
- `iClearErr` clears both flags on the next edge regardless of `iEnable`.
- If a new error occurs in the same enabled cycle as `iClearErr`, the new error wins and the flag reads 1.

**Status outputs:** `oFull` and `oEmpty` are combinational from `oDepth`.

## Timing

- **Reset values** (while `Reset` = 0, taking effect immediately):
  - `oIP = RESET_VECTOR`
  - `oDepth = 0`
  - `oFull = 0`, `oEmpty = 1`
  - `oOverflow = 0`, `oUnderflow = 0`, `oTrap = 0`
  - Stack contents are don't-care.
- **Deassertion:** the first advance happens on the first rising edge after `Reset` goes high with `iEnable` = 1.
- **Latency:** one cycle from a command strobe at an edge to the new `oIP`. `oIP` is stable for a full cycle so the ROM can look it up combinationally.
- **Strobes:** strobes are sampled only on enabled edges and must be stable around the rising edge. No handshake or acknowledge is returned.
- **Reset mid-operation:** a pending push or pop is lost, and the stack empties.
- **Storage:** the stack is a register array with synchronous writes and a combinational top-of-stack read. No RAM macro is inferred.

## Configuration

Macro `IPSEQ_TRAP_EN`:

**Defined:**
- A call with the stack full, or a return with the stack empty, sets `oIP <= TRAP_VECTOR`.
- `oTrap` pulses high for exactly one cycle, the cycle after the error edge.
- The stack is unchanged.

**Undefined:**
- An overflowing call still jumps, `oIP <= iTarget`, with the push dropped.
- An underflowing return behaves as sequential, `oIP <= oIP + 1`.
- `oTrap` is tied to 0.

The error flags behave identically in both builds.

## Test plan

1. **Reset and stall.** Assert `Reset` = 0 mid-run with `oIP` = 0x0023 and `oDepth` = 3. Then release it with `iEnable` = 0 for 4 cycles, then 1.
   - Required: `oIP` = 0x0000 and `oDepth` = 0 immediately on assertion.
   - Required: `oIP` holds 0x0000 for the 4 stalled cycles, then counts 0x0001, 0x0002.
2. **Nested call/return.** With `STACK_DEPTH` = 8:
   - At `oIP` = 0x0005, call 0x0040. At `oIP` = 0x0042, call 0x0080. Then issue two returns.
   - Required: `oIP` sequence 0x0040, 0x0041, 0x0042, 0x0080, 0x0043, 0x0006.
   - Required: `oDepth` sequence 1, 2, 1, 0.
3. **Overflow.** Issue 9 calls to 0x0100 with `STACK_DEPTH` = 8.
   - Required: `oFull` = 1 after the 8th call, and `oOverflow` = 1 after the 9th.
   - Required: `oDepth` stays at 8.
   - Required: `oIP` = 0x0100 without the macro, or 0xFFF0 with `oTrap` pulsed once when `IPSEQ_TRAP_EN` is defined.
4. **Underflow and flag clear.** Issue a return with the stack empty at `oIP` = 0x0010.
   - Required: `oUnderflow` = 1, and `oIP` = 0x0011, or 0xFFF0 when trapped.
   - Then assert `iClearErr` for one cycle. Required: `oUnderflow` = 0.
5. **Priority and wrap.** Assert `iCall`, `iRet` and `iBranch` together with `oDepth` = 1 and top entry 0x0033.
   - Required: `oIP` = 0x0033, `oDepth` = 0, no push.
   - Separately, at `oIP` = 0xFFFF with no command. Required: next `oIP` = 0x0000.
   - Separately, a call at 0xFFFF. Required: pushed value is 0x0000.
